// File: rtl/cache_mem_arbiter.sv
// Arbitrates the unified memory between I-cache line fills, D-cache line fills and D-side write-through stores.
// Optional macro CRITICAL_WORD_FIRST_EN starts each fill at the missed word instead of word 0.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned MEM_LAT        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_miss_req,
  input  logic [ADDR_WIDTH-1:0]             i_miss_addr,
  output logic                              i_fill_we,
  output logic                              i_fill_done,
  input  logic                              d_miss_req,
  input  logic [ADDR_WIDTH-1:0]             d_miss_addr,
  output logic                              d_fill_we,
  output logic                              d_fill_done,
  output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word,
  output logic [15:0]                       fill_data,
  input  logic                              d_wr_req,
  input  logic [ADDR_WIDTH-1:0]             d_wr_addr,
  input  logic [15:0]                       d_wr_data,
  output logic                              d_wr_ack,
  output logic                              mem_en,
  output logic                              mem_wr,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [15:0]                       mem_data_in,
  input  logic [15:0]                       mem_data_out,
  input  logic                              mem_data_valid,
  output logic                              busy
);

  localparam int unsigned WW  = $clog2(WORDS_PER_LINE);
  localparam int unsigned OFF = WW + 1;
  localparam int unsigned WCW = $clog2(MEM_LAT + 1) + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFF) - 1);
  localparam logic [WW-1:0]         LAST_WORD = WW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state, next_state;
  logic                  owner_d;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [WW-1:0]         start_word;
  logic [WW-1:0]         iss_cnt;
  logic [WW-1:0]         ret_cnt;
  logic                  rst_q;
  logic [WCW-1:0]        wait_cnt;

  logic [ADDR_WIDTH-1:0] miss_addr_sel;
  logic [WW-1:0]         iss_word;
  logic [WW-1:0]         ret_word;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  out_block;
  logic                  fill_ret;

  assign miss_addr_sel = d_miss_req ? d_miss_addr : i_miss_addr;
  assign iss_word      = WW'(iss_cnt + start_word);
  assign ret_word      = WW'(ret_cnt + start_word);
  assign issue_addr    = line_base | ADDR_WIDTH'({iss_word, 1'b0});
  // Outputs are forced quiet during reset and the cycle that follows it.
  assign out_block     = rst | rst_q;
  assign fill_ret      = (state != IDLE) && mem_data_valid;

  // State register, fill bookkeeping and the WAIT-length watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      line_base  <= '0;
      start_word <= '0;
      iss_cnt    <= '0;
      ret_cnt    <= '0;
      rst_q      <= 1'b1;
      wait_cnt   <= '0;
    end else begin
      rst_q <= 1'b0;
      state <= next_state;
      if (state == IDLE && next_state == ISSUE) begin
        owner_d   <= d_miss_req;
        line_base <= miss_addr_sel & LINE_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
        start_word <= miss_addr_sel[OFF-1:1];
`else
        start_word <= '0;
`endif
        iss_cnt <= '0;
        ret_cnt <= '0;
      end else begin
        if (state == ISSUE) iss_cnt <= WW'(iss_cnt + 1'b1);
        if (fill_ret && !out_block) ret_cnt <= WW'(ret_cnt + 1'b1);
      end
      if (state == WAIT) begin
        if (wait_cnt != '1) wait_cnt <= WCW'(wait_cnt + 1'b1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // All line reads have been issued, so data must finish returning within the memory latency.
  always_ff @(posedge clk) begin
    if (!rst && state == WAIT) assert (wait_cnt < WCW'(MEM_LAT));
  end

  // Next-state and memory/cache-side outputs.
  always_comb begin
    next_state  = state;
    i_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_we   = 1'b0;
    d_fill_done = 1'b0;
    fill_word   = '0;
    fill_data   = '0;
    d_wr_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    busy        = 1'b0;
    if (!out_block) begin
      fill_data = mem_data_out;
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_wr_addr;
            mem_data_in = d_wr_data;
            d_wr_ack    = 1'b1;
          end else if (d_miss_req || i_miss_req) begin
            next_state = ISSUE;
          end
        end
        ISSUE: begin
          mem_en   = 1'b1;
          mem_addr = issue_addr;
          busy     = 1'b1;
          if (iss_cnt == LAST_WORD) next_state = WAIT;
        end
        WAIT: busy = 1'b1;
        default: next_state = IDLE;
      endcase
      // Returning words go only to the cache that owns the current fill.
      if (fill_ret) begin
        fill_word = ret_word;
        if (owner_d) d_fill_we = 1'b1;
        else         i_fill_we = 1'b1;
        if (ret_cnt == LAST_WORD) begin
          if (owner_d) d_fill_done = 1'b1;
          else         i_fill_done = 1'b1;
          next_state = IDLE;
        end
      end
    end
  end

endmodule
